// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller.
// Holds the FSM state type, operand constants and the wait-counter width helper.
package pipeline_ctrl_pkg;

    typedef enum logic {
        StRun     = 1'b0,
        StMemWait = 1'b1
    } state_e;

    localparam logic [1:0] MEMOP_NONE = 2'b00;
    localparam logic [4:0] REG_ZERO   = 5'd0;

    // Wait counter never needs to hold more than latency-2; keep at least one bit.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat > 2) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs from the pipeline registers and stall/flush controls back to the datapath.
// master = datapath side, slave = stall controller.
interface pipeline_stall_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             ID_UsesRt;
    logic [1:0]       EX_MemRead;
    logic [4:0]       EX_Rd;
    logic [1:0]       MEM_MemRead;
    logic [1:0]       MEM_MemWrite;
    logic             MEM_Branch;
    logic             MEM_Zero;
    logic             MEM_Jump;

    logic             PCWrite;
    logic             IF_ID_Write;
    logic             ID_EX_Bubble;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             EX_MEM_Flush;
    logic             Freeze;
    logic             Busy;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_Rd,
        output MEM_MemRead, MEM_MemWrite, MEM_Branch, MEM_Zero, MEM_Jump,
        input  PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
        input  Freeze, Busy, StallCount, FlushCount
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_Rd,
        input  MEM_MemRead, MEM_MemWrite, MEM_Branch, MEM_Zero, MEM_Jump,
        output PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
        output Freeze, Busy, StallCount, FlushCount
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in EX whose destination is read by the instruction in ID.
// Register 0 is hardwired and never creates a dependency.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    input  logic [1:0] ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    output logic       load_use_o
);

    logic ex_is_load;
    logic rs_match;
    logic rt_match;

    always_comb begin
        ex_is_load = (ex_mem_read_i != MEMOP_NONE) && (ex_rd_i != REG_ZERO);
        rs_match   = (ex_rd_i == id_rs_i);
        rt_match   = id_uses_rt_i && (ex_rd_i == id_rt_i);
        load_use_o = ex_is_load && (rs_match || rt_match);
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller: freezes the pipe for multi-cycle MEM accesses, squashes on
// taken branches/jumps resolved in MEM, bubbles on load-use, and counts stall/flush events.
module pipeline_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned CNT_W       = 32
) (
    input logic                  Clk,
    input logic                  Rst,
    pipeline_stall_ctrl_if.slave bus
);

    localparam int unsigned CntW    = cnt_width(MEM_LATENCY);
    localparam bit          Freezes = (MEM_LATENCY > 1);
    localparam logic [CntW-1:0] CntLoad = CntW'((MEM_LATENCY >= 2) ? (MEM_LATENCY - 2) : 0);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic mem_acc;
    logic take;
    logic load_use;
    logic freeze;
    logic bubble;

    hazard_detect u_hazard_detect (
        .id_rs_i       (bus.ID_Rs),
        .id_rt_i       (bus.ID_Rt),
        .id_uses_rt_i  (bus.ID_UsesRt),
        .ex_mem_read_i (bus.EX_MemRead),
        .ex_rd_i       (bus.EX_Rd),
        .load_use_o    (load_use)
    );

    always_comb begin
        mem_acc = (bus.MEM_MemRead != MEMOP_NONE) || (bus.MEM_MemWrite != MEMOP_NONE);
        take    = bus.MEM_Jump || (bus.MEM_Branch && bus.MEM_Zero);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= StRun;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // The release cycle of MEMWAIT lets the access leave MEM, so it cannot re-trigger.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (mem_acc && Freezes) begin
                    state_d = StMemWait;
                    cnt_d   = CntLoad;
                end
            end
            StMemWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = StRun;
                end
            end
        endcase
    end

    always_comb begin
        freeze           = (state_q == StRun) ? (mem_acc && Freezes) : (cnt_q != '0);
        bubble           = 1'b0;
        bus.PCWrite      = 1'b1;
        bus.IF_ID_Write  = 1'b1;
        bus.IF_ID_Flush  = 1'b0;
        bus.ID_EX_Flush  = 1'b0;
        bus.EX_MEM_Flush = 1'b0;
        if (Rst) begin
            freeze           = 1'b0;
            bus.PCWrite      = 1'b0;
            bus.IF_ID_Write  = 1'b0;
            bus.IF_ID_Flush  = 1'b1;
            bus.ID_EX_Flush  = 1'b1;
            bus.EX_MEM_Flush = 1'b1;
        end else if (freeze) begin
            bus.PCWrite     = 1'b0;
            bus.IF_ID_Write = 1'b0;
        end else if (take) begin
            // The squashed ID instruction makes any load-use hazard irrelevant.
            bus.IF_ID_Flush  = 1'b1;
            bus.ID_EX_Flush  = 1'b1;
            bus.EX_MEM_Flush = 1'b1;
        end else if (load_use) begin
            bus.PCWrite     = 1'b0;
            bus.IF_ID_Write = 1'b0;
            bubble          = 1'b1;
        end
        bus.ID_EX_Bubble = bubble;
        bus.Freeze       = freeze;
        bus.Busy         = (state_q != StRun) && !Rst;
        bus.StallCount   = stall_cnt_q;
        bus.FlushCount   = flush_cnt_q;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(freeze || bubble);
        flush_cnt_d = flush_cnt_q + CNT_W'(take && !freeze && !Rst);
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed plus random checks of two controllers (MEM_LATENCY 4 and 1) sharing one input
// stream, against a per-access cycle-count reference model.
module tb_pipeline_stall_ctrl;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    logic [4:0] rs, rt, exrd;
    logic       ut, br, zr, jp;
    logic [1:0] exmr, mmr, mmw;

    pipeline_stall_ctrl_if #(.CNT_W(32)) bus4 ();
    pipeline_stall_ctrl_if #(.CNT_W(32)) bus1 ();

    assign bus4.ID_Rs = rs;        assign bus1.ID_Rs = rs;
    assign bus4.ID_Rt = rt;        assign bus1.ID_Rt = rt;
    assign bus4.ID_UsesRt = ut;    assign bus1.ID_UsesRt = ut;
    assign bus4.EX_MemRead = exmr; assign bus1.EX_MemRead = exmr;
    assign bus4.EX_Rd = exrd;      assign bus1.EX_Rd = exrd;
    assign bus4.MEM_MemRead = mmr; assign bus1.MEM_MemRead = mmr;
    assign bus4.MEM_MemWrite = mmw; assign bus1.MEM_MemWrite = mmw;
    assign bus4.MEM_Branch = br;   assign bus1.MEM_Branch = br;
    assign bus4.MEM_Zero = zr;     assign bus1.MEM_Zero = zr;
    assign bus4.MEM_Jump = jp;     assign bus1.MEM_Jump = jp;

    pipeline_stall_ctrl #(.MEM_LATENCY(4), .CNT_W(32)) dut4 (.Clk(Clk), .Rst(Rst), .bus(bus4));
    pipeline_stall_ctrl #(.MEM_LATENCY(1), .CNT_W(32)) dut1 (.Clk(Clk), .Rst(Rst), .bus(bus1));

    int          checks = 0;
    int          errors = 0;
    int          lat [2] = '{4, 1};
    int          k   [2];   // cycle index within the current MEM access, 0 = none
    logic [31:0] sc  [2];
    logic [31:0] fc  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Effective access cycle this clock: a new access starts at cycle 1.
    function automatic int eff(input int i);
        logic mem_acc;
        mem_acc = (mmr != 2'b00) || (mmw != 2'b00);
        return (k[i] == 0 && mem_acc && lat[i] > 1) ? 1 : k[i];
    endfunction

    // Packed {PCWrite, IF_ID_Write, Bubble, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Freeze, Busy}
    function automatic logic [7:0] expect_ctrl(input int i);
        int   e;
        logic frz, take, lu, busy;
        e    = eff(i);
        frz  = (e > 0) && (e < lat[i]);
        busy = (k[i] >= 2);
        take = jp || (br && zr);
        lu   = (exmr != 2'b00) && (exrd != 5'd0) && ((exrd == rs) || (ut && exrd == rt));
        if (Rst)       return 8'b0001_1100;
        else if (frz)  return {6'b000000, 1'b1, busy};
        else if (take) return {6'b110111, 1'b0, busy};
        else if (lu)   return {6'b001000, 1'b0, busy};
        else           return {6'b110000, 1'b0, busy};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            k[i] = 0; sc[i] = '0; fc[i] = '0;
        end
    endtask

    task automatic model_clock();
        for (int i = 0; i < 2; i++) begin
            logic [7:0] c;
            int         e;
            c = expect_ctrl(i);
            e = eff(i);
            if (c[1] || c[5]) sc[i] = sc[i] + 1;
            if ((jp || (br && zr)) && !c[1]) fc[i] = fc[i] + 1;
            k[i] = (e == 0 || e == lat[i]) ? 0 : e + 1;
        end
    endtask

    task automatic step(input string tag);
        #3;
        chk({tag, "/L4 ctrl"}, 32'({bus4.PCWrite, bus4.IF_ID_Write, bus4.ID_EX_Bubble,
            bus4.IF_ID_Flush, bus4.ID_EX_Flush, bus4.EX_MEM_Flush, bus4.Freeze, bus4.Busy}),
            32'(expect_ctrl(0)));
        chk({tag, "/L4 stall"}, bus4.StallCount, sc[0]);
        chk({tag, "/L4 flush"}, bus4.FlushCount, fc[0]);
        chk({tag, "/L1 ctrl"}, 32'({bus1.PCWrite, bus1.IF_ID_Write, bus1.ID_EX_Bubble,
            bus1.IF_ID_Flush, bus1.ID_EX_Flush, bus1.EX_MEM_Flush, bus1.Freeze, bus1.Busy}),
            32'(expect_ctrl(1)));
        chk({tag, "/L1 stall"}, bus1.StallCount, sc[1]);
        chk({tag, "/L1 flush"}, bus1.FlushCount, fc[1]);
        @(posedge Clk);
        if (!Rst) model_clock();
        #1;
    endtask

    task automatic idle();
        rs = 5'd1; rt = 5'd2; ut = 1'b0; exmr = 2'b00; exrd = 5'd0;
        mmr = 2'b00; mmw = 2'b00; br = 1'b0; zr = 1'b0; jp = 1'b0;
    endtask

    task automatic pulse_reset();
        Rst = 1'b1; model_reset();
        step("rst_pulse");
        Rst = 1'b0;
    endtask

    initial begin
        idle();
        Rst = 1'b1;
        model_reset();
        step("reset");
        Rst = 1'b0;
        step("first_run");

        // Reset in the middle of a memory wait
        mmw = 2'b01;
        step("mw_a");
        step("mw_b");
        Rst = 1'b1; model_reset();
        step("rst_mid_wait");
        Rst = 1'b0; mmw = 2'b00;
        step("after_rst");

        // Load-use on Rs, then on register 0
        exmr = 2'b01; exrd = 5'd8; rs = 5'd8;
        step("lu_rs");
        idle();
        step("lu_clear");
        exmr = 2'b01; exrd = 5'd0; rs = 5'd0;
        step("lu_r0");
        idle();

        // Rt gating
        pulse_reset();
        exmr = 2'b10; exrd = 5'd9; rt = 5'd9; ut = 1'b0;
        step("rt_unused");
        ut = 1'b1;
        step("rt_used");
        idle();
        step("rt_after");

        // Memory wait of latency 4
        mmw = 2'b01;
        for (int c = 0; c < 4; c++) step("memwait");
        idle();
        step("memwait_done");

        // Taken branch beats load-use
        pulse_reset();
        br = 1'b1; zr = 1'b1; exmr = 2'b01; exrd = 5'd5; rs = 5'd5;
        step("branch_lu");
        idle();
        step("branch_after");

        // Latency 1 read: the L1 controller must never freeze
        mmr = 2'b11;
        for (int c = 0; c < 3; c++) step("mr11");
        idle();
        step("mr11_done");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rs   = 5'($urandom_range(0, 3));
            rt   = 5'($urandom_range(0, 3));
            exrd = 5'($urandom_range(0, 3));
            ut   = 1'($urandom);
            exmr = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            mmr  = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            mmw  = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            br   = 1'($urandom);
            zr   = 1'($urandom);
            jp   = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 99) == 0) begin
                Rst = 1'b1; model_reset();
            end
            step("rand");
            Rst = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
